// File: rtl/chebyshev_eval_ctrl_if.sv
// Handshake/ROM bundle between the Chebyshev sequencer and its environment.
// master = coefficient store / requester side, slave = sequencer.
interface chebyshev_eval_ctrl_if #(
    parameter int WL = 16,
    parameter int AW = 4
);
    logic          start;
    logic [WL-1:0] x_in;
    logic [AW-1:0] coef_addr;
    logic [WL-1:0] coef_data;
    logic          busy;
    logic [WL-1:0] y_out;
    logic          y_valid;
    logic          sat_flag;

    modport master (
        output start, x_in, coef_data,
        input  coef_addr, busy, y_out, y_valid, sat_flag
    );

    modport slave (
        input  start, x_in, coef_data,
        output coef_addr, busy, y_out, y_valid, sat_flag
    );
endinterface

// File: rtl/chebyshev_eval_ctrl.sv
// Chebyshev series sequencer: y = sum c_k*T_k(x) on one shared signed multiplier.
// Optional clamping of T_k and y is enabled by defining CHEBY_SAT_EN.
module chebyshev_eval_ctrl #(
    parameter int WL    = 16,
    parameter int FRAC  = 12,
    parameter int ORDER = 8,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chebyshev_eval_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRIME, ACC, REC, FIN} state_t;

    localparam logic signed [WL-1:0] ONE = WL'(2 ** FRAC);

    state_t state_reg, state_next;

    logic signed [WL-1:0]   x_reg, t_cur_reg, t_prev_reg, y_reg;
    logic signed [WL+3:0]   acc_reg;
    logic [AW-1:0]          k_reg, addr_reg;
    logic                   sat_reg;

    logic signed [WL-1:0]   mul_a;
    logic signed [2*WL-1:0] prod, prod_sh;
    logic signed [WL+3:0]   term, acc_sum;
    logic signed [WL+1:0]   t_dbl, t_prev_ext, t_sum;
    logic signed [WL-1:0]   t_clamped, y_clamped;
    logic                   t_sat, y_sat;

    // Shared multiplier: coefficient term in ACC, recurrence product otherwise.
    assign mul_a      = (state_reg == ACC) ? bus.coef_data : x_reg;
    assign prod       = mul_a * t_cur_reg;
    assign prod_sh    = prod >>> FRAC;
    assign term       = prod_sh[WL+3:0];
    assign acc_sum    = acc_reg + term;
    assign t_dbl      = {prod_sh[WL:0], 1'b0};
    assign t_prev_ext = t_prev_reg;
    assign t_sum      = t_dbl - t_prev_ext;

`ifdef CHEBY_SAT_EN
    localparam logic signed [WL+1:0] T_MAX = (WL+2)'(2 ** FRAC);
    localparam logic signed [WL+1:0] T_MIN = -T_MAX;
    localparam logic signed [WL+3:0] Y_MAX = (WL+4)'(2 ** (WL-1) - 1);
    localparam logic signed [WL+3:0] Y_MIN = ~Y_MAX;

    always_comb begin
        t_clamped = t_sum[WL-1:0];
        t_sat     = 1'b0;
        if (t_sum > T_MAX) begin
            t_clamped = T_MAX[WL-1:0];
            t_sat     = 1'b1;
        end else if (t_sum < T_MIN) begin
            t_clamped = T_MIN[WL-1:0];
            t_sat     = 1'b1;
        end
        y_clamped = acc_sum[WL-1:0];
        y_sat     = 1'b0;
        if (acc_sum > Y_MAX) begin
            y_clamped = Y_MAX[WL-1:0];
            y_sat     = 1'b1;
        end else if (acc_sum < Y_MIN) begin
            y_clamped = Y_MIN[WL-1:0];
            y_sat     = 1'b1;
        end
    end
`else
    // Plain two's-complement wrap; sat_reg therefore never leaves 0.
    assign t_clamped = t_sum[WL-1:0];
    assign t_sat     = 1'b0;
    assign y_clamped = acc_sum[WL-1:0];
    assign y_sat     = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        bus.busy    = (state_reg != IDLE);
        bus.y_valid = (state_reg == FIN);
        case (state_reg)
            IDLE:    if (bus.start) state_next = PRIME;
            PRIME:   state_next = ACC;
            ACC:     state_next = (k_reg == AW'(ORDER)) ? FIN : REC;
            REC:     state_next = ACC;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            x_reg      <= '0;
            t_cur_reg  <= '0;
            t_prev_reg <= '0;
            y_reg      <= '0;
            acc_reg    <= '0;
            k_reg      <= '0;
            addr_reg   <= '0;
            sat_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (bus.start) begin
                    // T_prev seeded with x so the first REC yields T_1 = x.
                    x_reg      <= bus.x_in;
                    t_prev_reg <= bus.x_in;
                    t_cur_reg  <= ONE;
                    acc_reg    <= '0;
                    k_reg      <= '0;
                    addr_reg   <= '0;
                    sat_reg    <= 1'b0;
                end
                ACC: begin
                    acc_reg <= acc_sum;
                    if (k_reg == AW'(ORDER)) begin
                        y_reg   <= y_clamped;
                        sat_reg <= sat_reg | y_sat;
                    end else begin
                        addr_reg <= k_reg + 1'b1;
                    end
                end
                REC: begin
                    t_prev_reg <= t_cur_reg;
                    t_cur_reg  <= t_clamped;
                    k_reg      <= k_reg + 1'b1;
                    sat_reg    <= sat_reg | t_sat;
                end
                default: ;
            endcase
        end
    end

    assign bus.coef_addr = addr_reg;
    assign bus.y_out     = y_reg;
    assign bus.sat_flag  = sat_reg;
endmodule

// File: tb/tb_chebyshev_eval_ctrl.sv
// Self-checking bench for chebyshev_eval_ctrl: directed cases plus randomized
// evaluations compared against an arithmetic Chebyshev reference model.
module tb_chebyshev_eval_ctrl;
    localparam int WL    = 16;
    localparam int FRAC  = 12;
    localparam int ORDER = 8;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [WL-1:0] rom [2**AW];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chebyshev_eval_ctrl_if #(.WL(WL), .AW(AW)) bus ();

    chebyshev_eval_ctrl #(.WL(WL), .FRAC(FRAC), .ORDER(ORDER), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous-read coefficient ROM.
    always_ff @(posedge clk) bus.coef_data <= rom[bus.coef_addr];

    task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint wrap(input longint v, input int bits);
        longint m = longint'(1) << bits;
        longint r = v & (m - 1);
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Reference: direct forward recurrence with fixed-point floor scaling.
    function automatic void model(input logic [WL-1:0] xv, output logic [WL-1:0] y, output logic s);
        longint x  = longint'($signed(xv));
        longint tp = x;
        longint tc = longint'(1) << FRAC;
        longint acc = 0;
        longint tn;
        s = 1'b0;
        for (int k = 0; k <= ORDER; k++) begin
            acc = wrap(acc + ((longint'($signed(rom[k])) * tc) >>> FRAC), WL + 4);
            if (k < ORDER) begin
                tn = wrap(2 * ((x * tc) >>> FRAC) - tp, WL + 2);
`ifdef CHEBY_SAT_EN
                if (tn > (longint'(1) << FRAC)) begin
                    tn = longint'(1) << FRAC; s = 1'b1;
                end else if (tn < -(longint'(1) << FRAC)) begin
                    tn = -(longint'(1) << FRAC); s = 1'b1;
                end
`else
                tn = wrap(tn, WL);
`endif
                tp = tc;
                tc = tn;
            end
        end
`ifdef CHEBY_SAT_EN
        if (acc > 32767) begin
            y = 16'h7FFF; s = 1'b1;
        end else if (acc < -32768) begin
            y = 16'h8000; s = 1'b1;
        end else begin
            y = 16'(acc);
        end
`else
        y = 16'(acc);
`endif
    endfunction

    task automatic set_rom(input int idx, input logic [WL-1:0] val);
        for (int i = 0; i < 2**AW; i++) rom[i] = '0;
        if (idx >= 0) rom[idx] = val;
    endtask

    // One evaluation: start at cycle t, checks every cycle up to t+20.
    task automatic run_eval(input string tag, input logic [WL-1:0] x, input logic [WL-1:0] x_late,
                            input logic [WL-1:0] exp_y, input logic exp_sat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.x_in  = x_late;
                check_result({tag, ":addr_prime"}, 32'(bus.coef_addr), 32'd0);
            end
            check_result({tag, ":busy"}, 32'(bus.busy), 32'(c <= 19));
            check_result({tag, ":y_valid"}, 32'(bus.y_valid), 32'(c == 19));
            if (c >= 3 && c <= 17 && (c % 2) == 1)
                check_result({tag, ":addr_rec"}, 32'(bus.coef_addr), 32'((c - 1) / 2));
            if (c == 19) begin
                check_result({tag, ":y_out"}, 32'(bus.y_out), 32'(exp_y));
                check_result({tag, ":sat"}, 32'(bus.sat_flag), 32'(exp_sat));
            end
            if (c == 20) check_result({tag, ":y_hold"}, 32'(bus.y_out), 32'(exp_y));
        end
        $display("eval %s x=0x%h y=0x%h sat=%0d", tag, x, bus.y_out, bus.sat_flag);
    endtask

    initial begin
        logic [WL-1:0] ey;
        logic          es;
        logic [WL-1:0] xr;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.x_in  = '0;
        set_rom(-1, '0);
        repeat (3) @(negedge clk);
        check_result("rst:busy", 32'(bus.busy), 32'd0);
        check_result("rst:y_valid", 32'(bus.y_valid), 32'd0);
        check_result("rst:y_out", 32'(bus.y_out), 32'd0);
        check_result("rst:sat", 32'(bus.sat_flag), 32'd0);
        check_result("rst:addr", 32'(bus.coef_addr), 32'd0);
        rst_n = 1'b1;
        $display("reset released");

        set_rom(2, 16'h1000);
        run_eval("t2_half", 16'h0800, 16'h0800, 16'hF800, 1'b0);

        set_rom(1, 16'h1000);
        run_eval("t1_neg1", 16'hF000, 16'hF000, 16'hF000, 1'b0);

        for (int i = 0; i <= ORDER; i++) rom[i] = 16'h1000;
`ifdef CHEBY_SAT_EN
        run_eval("sum9", 16'h1000, 16'h1000, 16'h7FFF, 1'b1);
`else
        run_eval("sum9", 16'h1000, 16'h1000, 16'h9000, 1'b0);
`endif

        // start held high: results at t+19 and t+39, restart accepted at t+20.
        set_rom(2, 16'h1000);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = 16'h0800;
        for (int c = 1; c <= 39; c++) begin
            @(negedge clk);
            check_result("held:busy", 32'(bus.busy), 32'(c != 20));
            check_result("held:y_valid", 32'(bus.y_valid), 32'(c == 19 || c == 39));
            if (c == 19 || c == 39) check_result("held:y_out", 32'(bus.y_out), 32'h0000F800);
        end
        bus.start = 1'b0;
        @(negedge clk);
        $display("held start: two results observed window done");

        // Mid-evaluation reset aborts without a result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = 16'h0800;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 5) rst_n = 1'b0;
            if (c == 6) begin
                rst_n = 1'b1;
                check_result("abort:y_out", 32'(bus.y_out), 32'd0);
                check_result("abort:addr", 32'(bus.coef_addr), 32'd0);
            end
            if (c >= 6) begin
                check_result("abort:busy", 32'(bus.busy), 32'd0);
                check_result("abort:y_valid", 32'(bus.y_valid), 32'd0);
            end
        end
        $display("mid-run reset: no result emitted");
        run_eval("after_rst", 16'h0800, 16'h0800, 16'hF800, 1'b0);

        set_rom(3, 16'h1000);
        run_eval("x_late", 16'h1000, 16'h0000, 16'h1000, 1'b0);

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 2**AW; i++) rom[i] = WL'($urandom);
            if (n % 2 == 0) xr = WL'($urandom_range(0, 8192) - 4096);
            else            xr = WL'($urandom);
            model(xr, ey, es);
            run_eval($sformatf("rnd%0d", n), xr, WL'($urandom), ey, es);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/chebyshev_eval_ctrl.md
# chebyshev_eval_ctrl

Sequencer for scalar Chebyshev series evaluation, y = Σ c_k·T_k(x) for k = 0..ORDER, in signed fixed point. It runs the forward recurrence T_{k+1} = 2x·T_k − T_{k−1} on one shared signed multiplier. It fetches coefficients from an external synchronous-read coefficient ROM. It clamps intermediate and final values to the ranges the Chebyshev saturation stage enforces. It sits between the coefficient store and the downstream datapath consuming y.

## Interface
- WL, 16, total word length (two's complement).
- FRAC, 12, fractional bits; 1.0 = 2^FRAC; FRAC ≤ WL−2.
- ORDER, 8, highest polynomial degree N; ORDER ≥ 1.
- AW, 4, coefficient address width; 2^AW > ORDER.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin evaluation; honoured only in IDLE.
- x_in  in  WL  argument, sampled on the accepted start cycle only.
- coef_addr  out  AW  ROM address.
- coef_data  in  WL  ROM data; valid the cycle after coef_addr holds the address.
- busy  out  1  high in every state except IDLE.
- y_out  out  WL  result; holds until the next result.
- y_valid  out  1  one-cycle pulse, result valid.
- sat_flag  out  1  some clamp occurred in this evaluation; valid with y_valid.

## Operation
- States: IDLE, PRIME, ACC, REC, FIN.
- IDLE + start: latch x, set coef_addr←0, k←0, T_cur←1.0, T_prev←x, acc←0, clear sat_flag, go to PRIME.
- Seeding T_prev = x makes the first REC produce T_1 = 2x·1 − x = x.
- PRIME: one wait cycle for the ROM, then go to ACC.
- ACC: multiplier computes c_k·T_cur; acc ← acc + (product >>> FRAC).
  - k == ORDER: load y_out with the clamped acc and go to FIN.
  - Otherwise set coef_addr←k+1 and go to REC.
- REC: multiplier computes x·T_cur.
  - T_next = 2·(product >>> FRAC) − T_prev, computed in WL+2 bits.
  - T_prev←T_cur, T_cur←clamp(T_next), k←k+1, then go to ACC.
- FIN: y_valid=1 for this cycle, then return to IDLE.
- Arithmetic: products are full 2·WL signed; the shift is arithmetic with truncation toward −∞; the accumulator is WL+4 bits internally.
- start while busy (including the FIN cycle) is ignored; the evaluation in flight is unaffected.
- x_in changes after acceptance are ignored.
- rst_n=0 in any state forces the following on the next edge: IDLE, busy=0, y_valid=0, sat_flag=0, y_out=0, coef_addr=0, internal registers 0.
  - No partial result is ever emitted.

## Timing
- Accepted start at cycle t:
  - PRIME at t+1.
  - ACC(k=0) at t+2.
  - Each further term takes REC + ACC, 2 cycles.
  - Last ACC at t+2+2·ORDER.
  - FIN, with y_valid and y_out valid, at t+3+2·ORDER.
  - Earliest next start is accepted at t+4+2·ORDER.
- Default ORDER=8: y_valid at t+19; throughput one result per 20 cycles.
- coef_addr is 0 during PRIME and k+1 during REC; the same address appears as coef_data in the following ACC.
- Reset values: busy=0, y_valid=0, y_out=0, sat_flag=0, coef_addr=0.

## Configuration
- CHEBY_SAT_EN defined:
  - T_next is clamped to [−1.0, +1.0], i.e. [−2^FRAC, 2^FRAC].
  - The final acc is clamped to [−2^(WL−1), 2^(WL−1)−1].
  - Any clamp sets sat_flag, sticky until the next accepted start.
- CHEBY_SAT_EN undefined:
  - No clamping; T_cur and y_out are the low WL bits (two's-complement wrap).
  - sat_flag is tied to 0.

## Test plan
- WL=16, FRAC=12, ORDER=8; x=0x0800 (0.5); c2=0x1000, all other c=0; start at t -> y_out=0xF800 (−0.5), y_valid only at t+19, busy high t+1..t+19, sat_flag=0.
- x=0xF000 (−1.0); c1=0x1000, others 0 -> y_out=0xF000. Also check that T_k alternates ±1.0 with no clamp, so sat_flag=0.
- x=0x1000 (1.0); all nine c=0x1000; sum 9.0 -> with CHEBY_SAT_EN: y_out=0x7FFF, sat_flag=1. Without it: y_out=0x9000, sat_flag=0.
- start held high continuously from t -> results at t+19 and t+39; starts during busy are ignored. Also check coef_addr: 0 in PRIME, 1..8 in successive REC cycles.
- rst_n low for one cycle at t+5 mid-evaluation -> from t+6: busy=0, y_valid=0, y_out=0, coef_addr=0, with no y_valid pulse. A subsequent start with test-1 stimulus -> 0xF800 after 19 cycles.
- x=0x1000; c3=0x1000, others 0; x_in changed to 0 at t+1 -> y_out=0x1000 (T3(1)=1), which proves x is sampled only at start.
